// File: rtl/match_mode_counter_if.sv
// Command/status bundle for match_mode_counter: the master drives the command
// side and observes the count and terminal-event status.
interface match_mode_counter_if #(
  parameter int WIDTH   = 8,
  parameter int WRAPS_W = 8
);
  logic               en_i;
  logic [2:0]         cmd_i;
  logic [WIDTH-1:0]   load_value_i;
  logic [WIDTH-1:0]   output__;
  logic               at_zero_o;
  logic               at_max_o;
  logic               wrap_o;
  logic [WRAPS_W-1:0] wraps_o;

  modport master (
    output en_i, cmd_i, load_value_i,
    input  output__, at_zero_o, at_max_o, wrap_o, wraps_o
  );

  modport slave (
    input  en_i, cmd_i, load_value_i,
    output output__, at_zero_o, at_max_o, wrap_o, wraps_o
  );
endinterface

// File: rtl/match_mode_counter.sv
// Registered up/down modulo counter driven by a command tag; wraps or clamps
// at 0..MAX and counts wrap/clamp events.
module match_mode_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX      = 255,
  parameter int STEP     = 1,
  parameter int SATURATE = 0,
  parameter int WRAPS_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  match_mode_counter_if.slave  bus
);

  typedef enum logic [2:0] {
    CMD_HOLD  = 3'd0,
    CMD_INC   = 3'd1,
    CMD_DEC   = 3'd2,
    CMD_LOAD  = 3'd3,
    CMD_CLEAR = 3'd4
  } cmd_e;

  // Sums and differences are carried at WIDTH+1 bits so MAX = 2**WIDTH-1 cannot overflow.
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MAX) + (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);

  logic [WIDTH-1:0]   count_r;
  logic               wrap_r;
  logic [WRAPS_W-1:0] wraps_r;

  logic [2:0]         cmd_s;
  logic [WIDTH:0]     count_x_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   next_s;
  logic               wrap_s;

  // Next-count and wrap-event selection from the qualified command.
  always_comb begin
    cmd_s     = bus.en_i ? bus.cmd_i : CMD_HOLD;
    count_x_s = {1'b0, count_r};
    sum_s     = count_x_s + STEP_X;
    next_s    = count_r;
    wrap_s    = 1'b0;
    case (cmd_s)
      CMD_INC: begin
        if (sum_s <= MAX_X) begin
          next_s = WIDTH'(sum_s);
        end else if (SATURATE != 0) begin
          next_s = MAX_W;
          wrap_s = (count_r != MAX_W);
        end else begin
          next_s = WIDTH'(sum_s - MOD_X);
          wrap_s = 1'b1;
        end
      end
      CMD_DEC: begin
        if (count_x_s >= STEP_X) begin
          next_s = WIDTH'(count_x_s - STEP_X);
        end else if (SATURATE != 0) begin
          next_s = {WIDTH{1'b0}};
          wrap_s = (count_r != {WIDTH{1'b0}});
        end else begin
          next_s = WIDTH'(count_x_s + MOD_X - STEP_X);
          wrap_s = 1'b1;
        end
      end
      CMD_LOAD: begin
        if ({1'b0, bus.load_value_i} <= MAX_X) begin
          next_s = bus.load_value_i;
        end else begin
          next_s = MAX_W;
        end
      end
      CMD_CLEAR: begin
        next_s = {WIDTH{1'b0}};
      end
      default: begin
        next_s = count_r;
        wrap_s = 1'b0;
      end
    endcase
  end

  // Count, event pulse and event tally registers; the tally survives CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
      wrap_r  <= 1'b0;
      wraps_r <= {WRAPS_W{1'b0}};
    end else begin
      count_r <= next_s;
      wrap_r  <= wrap_s;
      if (wrap_s) begin
        wraps_r <= wraps_r + WRAPS_W'(1);
      end else begin
        wraps_r <= wraps_r;
      end
    end
  end

  assign bus.output__  = count_r;
  assign bus.at_zero_o = (count_r == {WIDTH{1'b0}});
  assign bus.at_max_o  = (count_r == MAX_W);
  assign bus.wrap_o    = wrap_r;
  assign bus.wraps_o   = wraps_r;

endmodule

// File: tb/tb_match_mode_counter.sv
// Directed bench for match_mode_counter: three configurations checked every
// cycle against an integer model, plus hand-computed literal expectations.
module tb_match_mode_counter;

  logic clk;
  logic rst_n;
  bit   chk_en;
  int   n_vec;
  int   n_bad;

  // Per-DUT stimulus and observed outputs: 0 = wrap MAX9/STEP3, 1 = saturate MAX9/STEP3, 2 = MAX255/STEP1/WRAPS_W2.
  bit         t_en   [3];
  int         t_cmd  [3];
  int         t_load [3];
  logic [7:0] o_cnt  [3];
  logic       o_az   [3];
  logic       o_am   [3];
  logic       o_wr   [3];
  logic [7:0] o_wraps[3];

  int m_cnt  [3];
  bit m_wrap [3];
  int m_wraps[3];

  match_mode_counter_if #(.WIDTH(8), .WRAPS_W(8)) ifa ();
  match_mode_counter_if #(.WIDTH(8), .WRAPS_W(8)) ifb ();
  match_mode_counter_if #(.WIDTH(8), .WRAPS_W(2)) ifc ();

  match_mode_counter #(.WIDTH(8), .MAX(9), .STEP(3), .SATURATE(0), .WRAPS_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  match_mode_counter #(.WIDTH(8), .MAX(9), .STEP(3), .SATURATE(1), .WRAPS_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  match_mode_counter #(.WIDTH(8), .MAX(255), .STEP(1), .SATURATE(0), .WRAPS_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  assign ifa.en_i = t_en[0];  assign ifa.cmd_i = 3'(t_cmd[0]);  assign ifa.load_value_i = 8'(t_load[0]);
  assign ifb.en_i = t_en[1];  assign ifb.cmd_i = 3'(t_cmd[1]);  assign ifb.load_value_i = 8'(t_load[1]);
  assign ifc.en_i = t_en[2];  assign ifc.cmd_i = 3'(t_cmd[2]);  assign ifc.load_value_i = 8'(t_load[2]);

  assign o_cnt[0] = ifa.output__;  assign o_az[0] = ifa.at_zero_o;  assign o_am[0] = ifa.at_max_o;
  assign o_wr[0]  = ifa.wrap_o;    assign o_wraps[0] = ifa.wraps_o;
  assign o_cnt[1] = ifb.output__;  assign o_az[1] = ifb.at_zero_o;  assign o_am[1] = ifb.at_max_o;
  assign o_wr[1]  = ifb.wrap_o;    assign o_wraps[1] = ifb.wraps_o;
  assign o_cnt[2] = ifc.output__;  assign o_az[2] = ifc.at_zero_o;  assign o_am[2] = ifc.at_max_o;
  assign o_wr[2]  = ifc.wrap_o;    assign o_wraps[2] = {6'b0, ifc.wraps_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_max(input int k);
    return (k == 2) ? 255 : 9;
  endfunction
  function automatic int cfg_step(input int k);
    return (k == 2) ? 1 : 3;
  endfunction
  function automatic bit cfg_sat(input int k);
    return (k == 1);
  endfunction
  function automatic int cfg_wmod(input int k);
    return (k == 2) ? 4 : 256;
  endfunction

  // Model: the count lives on a ring 0..MAX (or a clamped line when saturating).
  function automatic int nxt_cnt(input int k, input bit en, input int cmd, input int ld, input int c);
    int mx = cfg_max(k);
    int st = cfg_step(k);
    if (!en) return c;
    case (cmd)
      1: return (c + st <= mx) ? c + st : (cfg_sat(k) ? mx : (c + st) % (mx + 1));
      2: return (c >= st) ? c - st : (cfg_sat(k) ? 0 : (c - st + mx + 1) % (mx + 1));
      3: return (ld > mx) ? mx : ld;
      4: return 0;
      default: return c;
    endcase
  endfunction

  function automatic bit nxt_wrap(input int k, input bit en, input int cmd, input int c);
    if (!en) return 1'b0;
    if (cmd == 1) return (c + cfg_step(k) > cfg_max(k)) && !(cfg_sat(k) && c == cfg_max(k));
    if (cmd == 2) return (c < cfg_step(k)) && !(cfg_sat(k) && c == 0);
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_cnt[k]   <= 0;
        m_wrap[k]  <= 1'b0;
        m_wraps[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_cnt[k]  <= nxt_cnt(k, t_en[k], t_cmd[k], t_load[k], m_cnt[k]);
        m_wrap[k] <= nxt_wrap(k, t_en[k], t_cmd[k], m_cnt[k]);
        if (nxt_wrap(k, t_en[k], t_cmd[k], m_cnt[k]))
          m_wraps[k] <= (m_wraps[k] + 1) % cfg_wmod(k);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%h) expected %0d", name, act, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("model_cnt[%0d]", k), {24'b0, o_cnt[k]}, 32'(m_cnt[k]));
        check($sformatf("model_at_zero[%0d]", k), {31'b0, o_az[k]}, {31'b0, m_cnt[k] == 0});
        check($sformatf("model_at_max[%0d]", k), {31'b0, o_am[k]}, {31'b0, m_cnt[k] == cfg_max(k)});
        check($sformatf("model_wrap[%0d]", k), {31'b0, o_wr[k]}, {31'b0, m_wrap[k]});
        check($sformatf("model_wraps[%0d]", k), {24'b0, o_wraps[k]}, 32'(m_wraps[k]));
      end
    end
  end

  task automatic apply(input int k, input bit en, input int cmd, input int ld);
    t_en[k] = en;
    t_cmd[k] = cmd;
    t_load[k] = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    t_en[k] = 1'b1;
    t_cmd[k] = 0;
    t_load[k] = 0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    chk_en = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) idle(k);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    check("reset_cnt", {24'b0, o_cnt[0]}, 32'd0);
    check("reset_at_zero", {31'b0, o_az[0]}, 32'd1);
    check("reset_at_max", {31'b0, o_am[0]}, 32'd0);
    check("reset_wraps", {24'b0, o_wraps[0]}, 32'd0);
    rst_n = 1'b1;

    // Wrapping INC x4 from 0 with STEP 3, MAX 9.
    apply(0, 1'b1, 1, 0);  check("inc1", {24'b0, o_cnt[0]}, 32'd3);
    apply(0, 1'b1, 1, 0);  check("inc2", {24'b0, o_cnt[0]}, 32'd6);
    check("inc2_wrap", {31'b0, o_wr[0]}, 32'd0);
    apply(0, 1'b1, 1, 0);  check("inc3", {24'b0, o_cnt[0]}, 32'd9);
    check("inc3_at_max", {31'b0, o_am[0]}, 32'd1);
    check("inc3_wrap", {31'b0, o_wr[0]}, 32'd0);
    apply(0, 1'b1, 1, 0);  check("inc4", {24'b0, o_cnt[0]}, 32'd2);
    check("inc4_wrap", {31'b0, o_wr[0]}, 32'd1);
    check("inc4_wraps", {24'b0, o_wraps[0]}, 32'd1);

    // CLEAR then a wrapping DEC.
    apply(0, 1'b1, 4, 0);  check("clear", {24'b0, o_cnt[0]}, 32'd0);
    check("clear_wrap", {31'b0, o_wr[0]}, 32'd0);
    check("clear_keeps_wraps", {24'b0, o_wraps[0]}, 32'd1);
    apply(0, 1'b1, 2, 0);  check("dec_wrap_cnt", {24'b0, o_cnt[0]}, 32'd7);
    check("dec_wrap", {31'b0, o_wr[0]}, 32'd1);
    check("dec_wraps", {24'b0, o_wraps[0]}, 32'd2);
    apply(0, 1'b1, 0, 0);  check("hold_wrap_drop", {31'b0, o_wr[0]}, 32'd0);
    idle(0);

    // Saturating configuration: clamp pulses once only.
    apply(1, 1'b1, 3, 8);  check("sat_load8", {24'b0, o_cnt[1]}, 32'd8);
    apply(1, 1'b1, 1, 0);  check("sat_inc_a", {24'b0, o_cnt[1]}, 32'd9);
    check("sat_inc_a_wrap", {31'b0, o_wr[1]}, 32'd1);
    apply(1, 1'b1, 1, 0);  check("sat_inc_b", {24'b0, o_cnt[1]}, 32'd9);
    check("sat_inc_b_wrap", {31'b0, o_wr[1]}, 32'd0);
    check("sat_wraps", {24'b0, o_wraps[1]}, 32'd1);
    apply(1, 1'b1, 3, 200); check("load_clamp", {24'b0, o_cnt[1]}, 32'd9);
    apply(1, 1'b0, 1, 0);  check("en_low_hold", {24'b0, o_cnt[1]}, 32'd9);
    apply(1, 1'b1, 6, 0);  check("reserved_hold", {24'b0, o_cnt[1]}, 32'd9);
    apply(1, 1'b1, 3, 2);
    apply(1, 1'b1, 2, 0);  check("sat_dec", {24'b0, o_cnt[1]}, 32'd0);
    check("sat_dec_wrap", {31'b0, o_wr[1]}, 32'd1);
    apply(1, 1'b1, 2, 0);  check("sat_dec_held_wrap", {31'b0, o_wr[1]}, 32'd0);
    check("sat_dec_wraps", {24'b0, o_wraps[1]}, 32'd2);
    idle(1);

    // Asynchronous reset between edges while INC runs.
    t_en[0] = 1'b1;
    t_cmd[0] = 1;
    repeat (5) begin
      @(posedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", {24'b0, o_cnt[0]}, 32'd0);
    check("async_rst_wrap", {31'b0, o_wr[0]}, 32'd0);
    check("async_rst_wraps", {24'b0, o_wraps[0]}, 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_inc", {24'b0, o_cnt[0]}, 32'd3);
    idle(0);

    // 1024 unit steps on the full-range counter: four wraps roll the 2-bit tally.
    t_en[2] = 1'b1;
    t_cmd[2] = 1;
    repeat (256) @(posedge clk);
    #1;
    check("full_256_cnt", {24'b0, o_cnt[2]}, 32'd0);
    check("full_256_wraps", {24'b0, o_wraps[2]}, 32'd1);
    repeat (768) @(posedge clk);
    #1;
    check("full_1024_cnt", {24'b0, o_cnt[2]}, 32'd0);
    check("full_1024_wraps", {24'b0, o_wraps[2]}, 32'd0);
    check("full_1024_wrap", {31'b0, o_wr[2]}, 32'd1);
    idle(2);
    @(posedge clk);
    #1;

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/match_mode_counter.md
Name: match_mode_counter

Overview:
Parametrised successor to the single-cycle test-case counter. A registered up/down modulo counter whose next state is selected by a command tag through a match on cmd_i. Each command selects one operation: hold, step up, step down, load or clear. Supports arbitrary width, modulus, step size and a wrap/saturate mode, and reports terminal events. Used as the stateful match-on-enum output test and as a reusable tick/index generator.

Parameters:
WIDTH, 8, bit width of the count and load value
MAX, 255, terminal count (inclusive); legal range is 0..MAX; must satisfy MAX < 2**WIDTH
STEP, 1, increment/decrement amount; must satisfy 1 <= STEP <= MAX
SATURATE, 0, 0 = modulo wrap at the bounds; 1 = clamp at 0 or MAX
WRAPS_W, 8, width of the wrap-event counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en_i  input  1  command qualifier; when 0 the command is treated as HOLD
cmd_i  input  3  command tag: 0 HOLD, 1 INC, 2 DEC, 3 LOAD, 4 CLEAR, 5..7 reserved (treated as HOLD)
load_value_i  input  WIDTH  value applied on LOAD
output__  output  WIDTH  current count (registered)
at_zero_o  output  1  combinational from the register: output__ == 0
at_max_o  output  1  combinational from the register: output__ == MAX
wrap_o  output  1  registered one-cycle pulse on a wrap or clamp event
wraps_o  output  WRAPS_W  registered count of wrap/clamp events, modulo 2**WRAPS_W

Behaviour:
- Reset: rst_n low asynchronously forces output__=0, wrap_o=0 and wraps_o=0. Consequently at_zero_o=1 and at_max_o=(MAX==0). Reset takes effect mid-operation regardless of clk. The first update occurs on the first rising edge after rst_n deasserts.
- Latency: a command sampled at rising edge k is visible on output__ after edge k. There is no combinational path from cmd_i to any output.
- HOLD, reserved tags, or en_i=0: count unchanged, wrap_o=0.
- INC: let s = count + STEP, computed at WIDTH+1 bits.
  - s <= MAX: next = s.
  - s > MAX with SATURATE=0: next = s - (MAX+1), wrap_o=1.
  - s > MAX with SATURATE=1: next = MAX; wrap_o=1 only if count != MAX before the step; a clamp already held at MAX does not pulse.
- DEC: mirror of INC.
  - count >= STEP: next = count - STEP.
  - count < STEP with SATURATE=0: next = count + (MAX+1) - STEP, wrap_o=1.
  - count < STEP with SATURATE=1: next = 0; wrap_o=1 only if count != 0 before the step.
- LOAD: next = load_value_i if load_value_i <= MAX, otherwise MAX. wrap_o=0.
- CLEAR: next = 0, wrap_o=0.
- wrap_o is high for exactly the cycle following the event edge, then returns to 0 unless another event occurs.
- wraps_o increments by 1 on every cycle where wrap_o is set. It wraps from 2**WRAPS_W-1 to 0 silently. It is cleared only by reset; CLEAR does not affect it.
- All arithmetic is unsigned. Intermediate sums use WIDTH+1 bits so that MAX = 2**WIDTH-1 does not overflow.
- Back-to-back commands are accepted every cycle with no stall. Commands are mutually exclusive by encoding.

Test Plan:
1. WIDTH=8, MAX=9, STEP=3, SATURATE=0; reset, then INC x4 → output__ 3, 6, 9, 2. wrap_o pulses only after the 4th edge. wraps_o=1, at_max_o high in the cycle where output__=9.
2. Same configuration; CLEAR, then DEC x1 → output__=7, wrap_o=1, wraps_o increments.
3. SATURATE=1, MAX=9, STEP=3; LOAD 8, then INC x2 → output__ 9 with wrap_o=1, then 9 with wrap_o=0; wraps_o=1.
4. LOAD 200 with MAX=9 → output__=9. en_i=0 with cmd_i=INC → no change. cmd_i=6 → no change.
5. INC running continuously; assert rst_n low between clock edges → output__, wrap_o and wraps_o read 0 immediately. Release rst_n, then INC → output__=STEP one edge later.
6. WIDTH=8, MAX=255, STEP=1, WRAPS_W=2; INC x1024 → output__=0 and wraps_o=0 (wrap counter rolled over after 4 wraps); no X on any output.
